// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the HI/LO multiply/divide sequencer.
//   - md_op_e    : operation encodings as presented on the op port
//   - md_state_e : sequencer states (also driven out on dbg_state)
//   - ITER       : iteration count, equal to the operand width
//   - abs_if     : magnitude of a 32-bit value when the op is signed
// Optional feature macro used by the sequencer: HILO_DIV0_EARLY_OUT_EN.
package md_pkg;

    localparam int ITER = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } md_state_e;

    // |0x80000000| wraps back to 0x80000000, which is the correct
    // magnitude once the result is treated as unsigned.
    function automatic logic [31:0] abs_if(input logic [31:0] v, input logic en);
        return (en && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/md_iter_core.sv
// md_iter_core: one-step-per-cycle multiply/divide datapath.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   load            load acc with load_acc and the operand register with load_opnd
//   load_acc        initial 64-bit accumulator value
//   load_opnd       multiplicand (multiply) or divisor (divide) magnitude
//   step            perform one iteration this cycle
//   is_div          1: restoring divide step, 0: shift-add multiply step
//   acc             accumulator: {product_hi, product_lo} or {remainder, quotient}
module md_iter_core (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [63:0] load_acc,
    input  logic [31:0] load_opnd,
    input  logic        step,
    input  logic        is_div,
    output logic [63:0] acc
);

    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic [32:0] sum33;
    logic [33:0] trial;
    logic [63:0] mul_next;
    logic [63:0] div_next;

    always_comb begin
        // Multiply: upper half accumulates, lower half holds the multiplier
        // which is consumed LSB-first as the whole register shifts right.
        sum33    = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
        mul_next = acc_q[0] ? {sum33, acc_q[31:1]}
                            : {1'b0, acc_q[63:32], acc_q[31:1]};

        // Divide: upper half is the partial remainder, lower half shifts the
        // dividend out MSB-first while quotient bits shift in at bit 0.
        // The trial uses the remainder shifted left plus the next dividend
        // bit (33 bits); bit 33 of the difference is the borrow.
        trial    = {1'b0, acc_q[63:31]} - {2'b00, opnd_q};
        div_next = trial[33] ? {acc_q[62:0], 1'b0}
                             : {trial[31:0], acc_q[30:0], 1'b1};

        acc_d  = acc_q;
        opnd_d = opnd_q;
        if (load) begin
            acc_d  = load_acc;
            opnd_d = load_opnd;
        end else if (step) begin
            acc_d = is_div ? div_next : mul_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/hilo_md_ctrl.sv
// hilo_md_ctrl: multiply/divide sequencer and owner of architectural HI/LO.
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   start, op, a, b    mult/div request from EX (op: 00 MULT 01 MULTU 10 DIV 11 DIVU)
//   cancel             flush: abort any operation, HI/LO untouched
//   hi_we, lo_we, wdata MTHI/MTLO writes, honoured only while idle
//   stall              freeze IF/ID/EX while the operation runs
//   busy               sequencer is not idle
//   hi, lo             architectural HI/LO (registered)
//   dbg_state          current sequencer state (md_state_e encoding)
// Build option: define HILO_DIV0_EARLY_OUT_EN to skip the iterations for a
// divide by zero and go straight to the sign-fix step with results preset.
module hilo_md_ctrl
    import md_pkg::*;
#(
    parameter int ITER = md_pkg::ITER
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [1:0]  dbg_state
);

    localparam int CNT_W = $clog2(ITER);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic               in_signed;
    logic [31:0]        abs_a, abs_b;
    logic               core_load, core_step;
    logic [63:0]        core_load_acc;
    logic [31:0]        core_load_opnd;
    logic [63:0]        acc;
    logic [63:0]        prod_fix;
    logic [31:0]        quot_fix, rem_fix;
    logic               op_signed;

    md_iter_core u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (core_load),
        .load_acc  (core_load_acc),
        .load_opnd (core_load_opnd),
        .step      (core_step),
        .is_div    (op_q[1]),
        .acc       (acc)
    );

    // Operand preparation: signed ops (op[0]==0) work on magnitudes.
    always_comb begin
        in_signed      = ~op[0];
        abs_a          = abs_if(a, in_signed);
        abs_b          = abs_if(b, in_signed);
        core_load_acc  = op[1] ? {32'd0, abs_a} : {32'd0, abs_b};
        core_load_opnd = op[1] ? abs_b : abs_a;
`ifdef HILO_DIV0_EARLY_OUT_EN
        // Same values the 32 iterations would leave behind for a zero divisor.
        if (op[1] && (b == 32'd0)) begin
            core_load_acc = {abs_a, 32'hFFFF_FFFF};
        end
`endif
    end

    // Sign fix of the finished magnitude result.
    always_comb begin
        op_signed = ~op_q[0];
        prod_fix  = (op_signed && (sa_q ^ sb_q)) ? (64'd0 - acc) : acc;
        quot_fix  = (op_signed && (sa_q ^ sb_q)) ? (32'd0 - acc[31:0]) : acc[31:0];
        rem_fix   = (op_signed && sa_q) ? (32'd0 - acc[63:32]) : acc[63:32];
    end

    // Next-state and register updates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        core_load = 1'b0;
        core_step = 1'b0;

        if (cancel) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                    if (start) begin
                        core_load = 1'b1;
                        op_d      = op;
                        sa_d      = in_signed & a[31];
                        sb_d      = in_signed & b[31];
                        cnt_d     = '0;
                        state_d   = ST_CALC;
`ifdef HILO_DIV0_EARLY_OUT_EN
                        if (op[1] && (b == 32'd0)) state_d = ST_FIX;
`endif
                    end
                end
                ST_CALC: begin
                    core_step = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (op_q[1]) begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end else begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= 2'b00;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Stall drops in DONE so the held instruction advances exactly once,
    // and is forced low during a flush.
    assign stall = ~cancel & (((state_q == ST_IDLE) & start) |
                              (state_q == ST_CALC) | (state_q == ST_FIX));
    assign busy      = (state_q != ST_IDLE);
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;

endmodule
